// File: rtl/balance_display_if.sv
// balance_display_if
//   Bundles the data inputs and display outputs of balance_display.
//   master : the side that supplies balance/status/beep and watches the display
//   slave  : balance_display itself
//   balance  [7:0]  unsigned balance, 0..255
//   status   [3:0]  status nibble shown as hex on digit 3
//   beep            buzzer request, lights the digit-3 decimal point
//   seg_an   [3:0]  digit anodes, active-low one-hot
//   seg_cat  [6:0]  cathodes {g,f,e,d,c,b,a}, active-low
//   seg_dp          decimal point, active-low
//   busy            conversion in progress
interface balance_display_if;
  logic [7:0] balance;
  logic [3:0] status;
  logic       beep;
  logic [3:0] seg_an;
  logic [6:0] seg_cat;
  logic       seg_dp;
  logic       busy;

  modport master (output balance, status, beep, input seg_an, seg_cat, seg_dp, busy);
  modport slave  (input balance, status, beep, output seg_an, seg_cat, seg_dp, busy);
endinterface

// File: rtl/balance_display.sv
// balance_display
//   Drives a 4-digit multiplexed 7-segment display. Digits 2..0 show the 8-bit
//   balance in decimal (sequential double-dabble, 8 shift cycles), digit 3 shows
//   the status nibble in hex, and the digit-3 decimal point follows beep.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : balance_display_if.slave (balance, status, beep in; seg_an, seg_cat,
//          seg_dp, busy out)
//   SCAN_DIV : clk cycles each digit is driven (>= 2)
//   BLANK_LZ : 1 blanks leading zeros of the decimal field
module balance_display #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic             clk,
  input logic             rst,
  balance_display_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_r;
  logic             force_r;
  logic [7:0]       last_bin_r;
  logic [7:0]       bin_r;
  logic [9:0]       scratch_r;
  logic [2:0]       bit_cnt_r;
  logic             busy_r;
  logic [9:0]       disp_bcd_r;
  logic             disp_en_r;
  logic [CNT_W-1:0] scan_cnt_r;
  logic [1:0]       idx_r;
  logic [3:0]       seg_an_r;
  logic [6:0]       seg_cat_r;
  logic             seg_dp_r;

  logic             wrap_s;
  logic [1:0]       idx_nxt_s;
  logic [9:0]       bcd_nxt_s;
  logic             en_nxt_s;
  logic [3:0]       hund_s;
  logic [3:0]       an_nxt_s;
  logic [6:0]       cat_nxt_s;
  logic             dp_nxt_s;

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h10;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      4'hF: c = 7'h0E;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // One double-dabble step on {hundreds[1:0], tens, units, bin}. Hundreds never
  // exceeds 2 for an 8-bit input, so it needs no add-3 correction and its top
  // bit is always zero before the final shift.
  function automatic logic [17:0] dd_step(input logic [17:0] x);
    logic [3:0] t;
    logic [3:0] u;
    t = (x[15:12] >= 4'd5) ? x[15:12] + 4'd3 : x[15:12];
    u = (x[11:8]  >= 4'd5) ? x[11:8]  + 4'd3 : x[11:8];
    return {x[16], t, u, x[7:0], 1'b0};
  endfunction

  // Conversion FSM: sample on change (or forced after reset), 8 shifts, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      force_r    <= 1'b1;
      last_bin_r <= 8'd0;
      bin_r      <= 8'd0;
      scratch_r  <= 10'd0;
      bit_cnt_r  <= 3'd0;
      busy_r     <= 1'b0;
      disp_bcd_r <= 10'd0;
      disp_en_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((bus.balance != last_bin_r) || force_r) begin
            bin_r      <= bus.balance;
            last_bin_r <= bus.balance;
            scratch_r  <= 10'd0;
            bit_cnt_r  <= 3'd0;
            force_r    <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {scratch_r, bin_r} <= dd_step({scratch_r, bin_r});
          bit_cnt_r          <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Whole result lands in one edge so no partial value is ever shown.
          disp_bcd_r <= scratch_r;
          disp_en_r  <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Next display contents, built from post-edge values so the segment outputs
  // change on the same edge as the digit index and the display register.
  always_comb begin
    wrap_s    = (scan_cnt_r == CNT_W'(SCAN_DIV - 1));
    idx_nxt_s = wrap_s ? idx_r + 2'd1 : idx_r;
    bcd_nxt_s = (state_r == ST_DONE) ? scratch_r : disp_bcd_r;
    en_nxt_s  = (state_r == ST_DONE) | disp_en_r;
    hund_s    = {2'b00, bcd_nxt_s[9:8]};
    an_nxt_s  = ~(4'b0001 << idx_nxt_s);
    dp_nxt_s  = ~((idx_nxt_s == 2'd3) & bus.beep);
    case (idx_nxt_s)
      2'd0: cat_nxt_s = seg_encode(bcd_nxt_s[3:0]);
      2'd1: begin
        if (BLANK_LZ && (hund_s == 4'd0) && (bcd_nxt_s[7:4] == 4'd0)) begin
          cat_nxt_s = 7'h7F;
        end else begin
          cat_nxt_s = seg_encode(bcd_nxt_s[7:4]);
        end
      end
      2'd2: begin
        if (BLANK_LZ && (hund_s == 4'd0)) begin
          cat_nxt_s = 7'h7F;
        end else begin
          cat_nxt_s = seg_encode(hund_s);
        end
      end
      2'd3: cat_nxt_s = seg_encode(bus.status);
      default: cat_nxt_s = 7'h7F;
    endcase
    if (!en_nxt_s) begin
      an_nxt_s  = 4'b1111;
      cat_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end else begin
      an_nxt_s = an_nxt_s;
    end
  end

  // Scan counter, digit index and registered segment outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd0;
      seg_an_r   <= 4'b1111;
      seg_cat_r  <= 7'h7F;
      seg_dp_r   <= 1'b1;
    end else begin
      scan_cnt_r <= wrap_s ? '0 : scan_cnt_r + CNT_W'(1);
      idx_r      <= idx_nxt_s;
      seg_an_r   <= an_nxt_s;
      seg_cat_r  <= cat_nxt_s;
      seg_dp_r   <= dp_nxt_s;
    end
  end

  assign bus.seg_an  = seg_an_r;
  assign bus.seg_cat = seg_cat_r;
  assign bus.seg_dp  = seg_dp_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_balance_display.sv
module tb_balance_display;

  logic clk;
  logic rst;

  balance_display_if bus_a();
  balance_display_if bus_b();

  assign bus_b.balance = bus_a.balance;
  assign bus_b.status  = bus_a.status;
  assign bus_b.beep    = bus_a.beep;

  balance_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  balance_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bal;
    logic [3:0] st;
    logic       bp;
    logic [6:0] c0, c1, c2, c3;
    logic       dp3;
    logic [6:0] n1, n2;
  } vec_t;

  vec_t vecs [8];

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] cat_a [4];
  logic [6:0] cat_b [4];
  logic       dp_a  [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int an_to_digit(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Wait for one conversion to start and finish, bounded.
  task automatic wait_conv(input string name);
    int k;
    k = 0;
    while (bus_a.busy !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    while (bus_a.busy !== 1'b0 && k < 80) begin @(negedge clk); k++; end
    check(name, (k < 80) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Sample a full scan of both displays (16 clks covers all four digits).
  task automatic capture_frame(input string name);
    int bad;
    int d;
    int db;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cat_a[i] = 7'hxx; cat_b[i] = 7'hxx; dp_a[i] = 1'bx;
    end
    repeat (16) begin
      @(negedge clk);
      d  = an_to_digit(bus_a.seg_an);
      db = an_to_digit(bus_b.seg_an);
      if (d < 0 || db != d) begin
        bad++;
      end else begin
        cat_a[d] = bus_a.seg_cat;
        dp_a[d]  = bus_a.seg_dp;
        cat_b[d] = bus_b.seg_cat;
      end
    end
    check({name, "_anode"}, bad, 32'd0);
  endtask

  // Reset with the current inputs, then follow the forced conversion edge by edge.
  task automatic do_reset(input string name);
    int busy_cnt;
    int early_bad;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({name, "_rst_an"},   bus_a.seg_an,  4'b1111);
    check({name, "_rst_cat"},  bus_a.seg_cat, 7'h7F);
    check({name, "_rst_dp"},   bus_a.seg_dp,  1'b1);
    check({name, "_rst_busy"}, bus_a.busy,    1'b0);
    rst = 1'b0;
    busy_cnt  = 0;
    early_bad = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (bus_a.busy === 1'b1) busy_cnt++;
      if (e <= 9 && (bus_a.seg_an !== 4'b1111 || bus_a.seg_cat !== 7'h7F || bus_a.seg_dp !== 1'b1))
        early_bad++;
      if (e == 10) begin
        check({name, "_busy_e10"}, bus_a.busy, 1'b0);
        check({name, "_an_e10"},   bus_a.seg_an, 4'b1011);
      end
    end
    check({name, "_busy_cycles"}, busy_cnt, 32'd9);
    check({name, "_hidden_until_done"}, early_bad, 32'd0);
  endtask

  initial begin
    logic [3:0] an_seq [4];
    int k, bad, phase, ph1_samples, d;
    logic prev_busy;
    logic [6:0] exp_cat;
    logic [6:0] old_c [3];
    logic [6:0] ten_c [3];
    logic [6:0] two_c [3];

    //          bal     st    bp    c0     c1     c2     c3     dp3   n1     n2
    vecs[0] = '{8'd255, 4'hA, 1'b1, 7'h12, 7'h12, 7'h24, 7'h08, 1'b0, 7'h12, 7'h24};
    vecs[1] = '{8'd105, 4'h0, 1'b0, 7'h12, 7'h40, 7'h79, 7'h40, 1'b1, 7'h40, 7'h79};
    vecs[2] = '{8'd7,   4'hF, 1'b1, 7'h78, 7'h7F, 7'h7F, 7'h0E, 1'b0, 7'h40, 7'h40};
    vecs[3] = '{8'd99,  4'hB, 1'b0, 7'h10, 7'h10, 7'h7F, 7'h03, 1'b1, 7'h10, 7'h40};
    vecs[4] = '{8'd128, 4'h5, 1'b0, 7'h00, 7'h24, 7'h79, 7'h12, 1'b1, 7'h24, 7'h79};
    vecs[5] = '{8'd200, 4'hC, 1'b1, 7'h40, 7'h40, 7'h24, 7'h46, 1'b0, 7'h40, 7'h24};
    vecs[6] = '{8'd10,  4'hD, 1'b0, 7'h40, 7'h79, 7'h7F, 7'h21, 1'b1, 7'h79, 7'h40};
    vecs[7] = '{8'd0,   4'hA, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h08, 1'b0, 7'h40, 7'h40};

    clk = 1'b0;
    rst = 1'b1;
    bus_a.balance = 8'd0;
    bus_a.status  = 4'h0;
    bus_a.beep    = 1'b0;

    // Power-up: reset with balance 0, forced conversion shows "  0".
    do_reset("pwr");
    capture_frame("pwr");
    check("pwr_d0", cat_a[0], 7'h40);
    check("pwr_d1", cat_a[1], 7'h7F);
    check("pwr_d2", cat_a[2], 7'h7F);

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bus_a.balance = vecs[v].bal;
      bus_a.status  = vecs[v].st;
      bus_a.beep    = vecs[v].bp;
      wait_conv($sformatf("v%0d_conv", v));
      repeat (2) @(negedge clk);
      capture_frame($sformatf("v%0d", v));
      check($sformatf("v%0d_d0", v), cat_a[0], vecs[v].c0);
      check($sformatf("v%0d_d1", v), cat_a[1], vecs[v].c1);
      check($sformatf("v%0d_d2", v), cat_a[2], vecs[v].c2);
      check($sformatf("v%0d_d3", v), cat_a[3], vecs[v].c3);
      check($sformatf("v%0d_dp3", v), dp_a[3], vecs[v].dp3);
      check($sformatf("v%0d_dp012", v), {dp_a[2], dp_a[1], dp_a[0]}, 3'b111);
      check($sformatf("v%0d_nb_d0", v), cat_b[0], vecs[v].c0);
      check($sformatf("v%0d_nb_d1", v), cat_b[1], vecs[v].n1);
      check($sformatf("v%0d_nb_d2", v), cat_b[2], vecs[v].n2);
    end

    // Anode scan order with SCAN_DIV=4 (status A, beep 1 still applied).
    an_seq[0] = 4'hE; an_seq[1] = 4'hD; an_seq[2] = 4'hB; an_seq[3] = 4'h7;
    k = 0;
    @(negedge clk);
    while (k < 20) begin
      logic [3:0] prev_an;
      prev_an = bus_a.seg_an;
      @(negedge clk);
      k++;
      if (prev_an != 4'hE && bus_a.seg_an == 4'hE) break;
    end
    check("scan_sync", (k < 20) ? 32'd1 : 32'd0, 32'd1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (bus_a.seg_an !== an_seq[i / 4]) bad++;
    end
    check("scan_order", bad, 32'd0);

    // Balance changes 10 -> 200 on the third SHIFT cycle; display goes 0, 10, 200.
    old_c[0] = 7'h40; old_c[1] = 7'h7F; old_c[2] = 7'h7F;
    ten_c[0] = 7'h40; ten_c[1] = 7'h79; ten_c[2] = 7'h7F;
    two_c[0] = 7'h40; two_c[1] = 7'h40; two_c[2] = 7'h24;
    @(negedge clk);
    bus_a.balance = 8'd10;
    k = 0;
    while (bus_a.busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("chg_start", bus_a.busy, 1'b1);
    repeat (2) @(negedge clk);
    bus_a.balance = 8'd200;
    phase = 0; bad = 0; ph1_samples = 0; prev_busy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (prev_busy === 1'b1 && bus_a.busy === 1'b0) phase++;
      prev_busy = bus_a.busy;
      d = an_to_digit(bus_a.seg_an);
      if (d >= 0 && d <= 2) begin
        exp_cat = (phase == 0) ? old_c[d] : (phase == 1) ? ten_c[d] : two_c[d];
        if (phase == 1) ph1_samples++;
        if (bus_a.seg_cat !== exp_cat) bad++;
      end
    end
    check("chg_phases", phase, 32'd2);
    check("chg_values", bad, 32'd0);
    check("chg_10_seen", (ph1_samples > 0) ? 32'd1 : 32'd0, 32'd1);

    // Reset during SHIFT while the display is scanning.
    @(negedge clk);
    bus_a.balance = 8'd77;
    k = 0;
    while (bus_a.busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    do_reset("mid");
    capture_frame("mid");
    check("mid_d0", cat_a[0], 7'h78);
    check("mid_d1", cat_a[1], 7'h78);
    check("mid_d2", cat_a[2], 7'h7F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
